ascon_perm_seq: RTL

ASCON_PERM_SEQ -- requirements
Module: ascon_perm_seq

---
 rtl/ascon_perm_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ascon_perm_seq.sv
// Sequencer that streams a 320-bit Ascon state through an external serial round core,
// one 64-bit slice per cycle, for a = 1..12 rounds (each round: 5 load + 6 read cycles).
module ascon_perm_seq #(
    parameter int BW = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5*BW-1:0] in_state,
    input  logic [3:0]      in_rounds,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5*BW-1:0] out_state,
    output logic            busy,
    output logic            core_en,
    output logic [2:0]      core_slice_idx,
    output logic [3:0]      core_round,
    output logic [BW-1:0]   core_slice_in,
    input  logic [BW-1:0]   core_slice_out
);

    typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

    localparam logic [3:0] LAST_RND = 4'd11;

    state_t            r_state;
    state_t            w_next;
    logic [BW-1:0]     r_st [0:4];
    logic [3:0]        r_rnd;
    logic [2:0]        r_phase;
    logic [5*BW-1:0]   r_out;
    logic [3:0]        w_rounds_eff;
    logic [BW-1:0]     w_load_slice;

    // Out-of-range round counts fall back to the full 12-round permutation.
    assign w_rounds_eff = ((in_rounds == 4'd0) || (in_rounds > 4'd12)) ? 4'd12 : in_rounds;
    assign out_state    = r_out;

    always_comb begin
        w_load_slice = '0;
        case (r_phase)
            3'd0:    w_load_slice = r_st[0];
            3'd1:    w_load_slice = r_st[1];
            3'd2:    w_load_slice = r_st[2];
            3'd3:    w_load_slice = r_st[3];
            3'd4:    w_load_slice = r_st[4];
            default: w_load_slice = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        busy           = 1'b1;
        core_en        = 1'b0;
        core_slice_idx = 3'd0;
        core_round     = 4'd0;
        core_slice_in  = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next = LOAD;
            end
            LOAD: begin
                core_en        = 1'b1;
                core_slice_idx = r_phase;
                core_slice_in  = w_load_slice;
                core_round     = r_rnd;
                if (r_phase == 3'd4) w_next = READ;
            end
            READ: begin
                core_round     = r_rnd;
                // The sixth read cycle only collects the registered x4 slice.
                core_slice_idx = (r_phase == 3'd5) ? 3'd4 : r_phase;
                if (r_phase == 3'd5) w_next = (r_rnd == LAST_RND) ? DONE : LOAD;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 5; i++) r_st[i] <= '0;
            r_rnd   <= 4'd0;
            r_phase <= 3'd0;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_st[0] <= in_state[5*BW-1:4*BW];
                        r_st[1] <= in_state[4*BW-1:3*BW];
                        r_st[2] <= in_state[3*BW-1:2*BW];
                        r_st[3] <= in_state[2*BW-1:BW];
                        r_st[4] <= in_state[BW-1:0];
                        r_rnd   <= 4'd12 - w_rounds_eff;
                        r_phase <= 3'd0;
                    end
                end
                LOAD: begin
                    r_phase <= (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
                end
                READ: begin
                    for (int i = 0; i < 5; i++) begin
                        if (r_phase == 3'(i + 1)) r_st[i] <= core_slice_out;
                    end
                    if (r_phase == 3'd5) begin
                        r_phase <= 3'd0;
                        if (r_rnd == LAST_RND)
                            r_out <= {r_st[0], r_st[1], r_st[2], r_st[3], core_slice_out};
                        else
                            r_rnd <= r_rnd + 4'd1;
                    end else begin
                        r_phase <= r_phase + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
